// File: rtl/fsmc_dds_pkg.sv
// Shared constants, register map, FSM encoding and register payloads for the FSMC DDS register block.
package fsmc_dds_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned FTW_W    = 32;
    localparam int unsigned WAVE_W   = 2;
    localparam int unsigned REGION_W = 4;
    localparam int unsigned OFFSET_W = 4;
    localparam int unsigned CTRL_W   = 15;

    localparam logic [REGION_W-1:0] BASE_REGION_DEFAULT = 4'b1010;

    localparam logic [OFFSET_W-1:0] OFF_FTW_LO = 4'd0;
    localparam logic [OFFSET_W-1:0] OFF_FTW_HI = 4'd1;
    localparam logic [OFFSET_W-1:0] OFF_PHASE  = 4'd2;
    localparam logic [OFFSET_W-1:0] OFF_AMPL   = 4'd3;
    localparam logic [OFFSET_W-1:0] OFF_CTRL   = 4'd4;
    localparam logic [OFFSET_W-1:0] OFF_STATUS = 4'd5;
    localparam logic [OFFSET_W-1:0] OFF_ID     = 4'd7;

    localparam logic [DATA_W-1:0] ID_VALUE        = 16'hDD50;
    localparam int unsigned       CTRL_COMMIT_BIT = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4,
        ST_WAIT  = 3'd5
    } fsm_state_e;

    // Host-visible staging copy; ctrl keeps CTRL[14:0], bit 15 is the commit strobe.
    typedef struct packed {
        logic [FTW_W-1:0]  ftw;
        logic [DATA_W-1:0] phase;
        logic [DATA_W-1:0] ampl;
        logic [CTRL_W-1:0] ctrl;
    } dds_shadow_t;

    // Values presented to the DDS core.
    typedef struct packed {
        logic [FTW_W-1:0]  ftw;
        logic [DATA_W-1:0] phase;
        logic [DATA_W-1:0] ampl;
        logic [WAVE_W-1:0] wave;
    } dds_active_t;

endpackage

// File: rtl/fsmc_dds_regs_if.sv
// FSMC multiplexed-bus signals between the host (master) and the register block (slave).
interface fsmc_dds_regs_if;
    import fsmc_dds_pkg::*;

    logic              NE1;
    logic              NADV;
    logic              NWE;
    logic              NOE;
    logic [DATA_W-1:0] AD_IN;
    logic              A16;
    logic              A17;
    logic              A18;
    logic [DATA_W-1:0] AD_OUT;
    logic              AD_OE;

    modport master (
        output NE1, NADV, NWE, NOE, AD_IN, A16, A17, A18,
        input  AD_OUT, AD_OE
    );

    modport slave (
        input  NE1, NADV, NWE, NOE, AD_IN, A16, A17, A18,
        output AD_OUT, AD_OE
    );

endinterface

// File: rtl/fsmc_sync.sv
// Multi-flop synchronizer for one asynchronous FSMC strobe, with rise/fall detection.
// Flops reset to 1 so an idle (high) bus produces no edge on reset release.
module fsmc_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the input through the chain and keep the last synchronized value.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level  = sync_q[STAGES-1];
    assign rise_c = level & ~prev_q;
    assign fall_c = ~level & prev_q;

endmodule

// File: rtl/fsmc_dds_regs.sv
// FSMC slave holding DDS shadow/active registers with commit-on-CTRL[15].
// Optional readback path enabled by defining FSMC_DDS_READBACK_EN.
module fsmc_dds_regs
    import fsmc_dds_pkg::*;
#(
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [REGION_W-1:0]  BASE_REGION = BASE_REGION_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST,
    fsmc_dds_regs_if.slave      bus,
    output logic [FTW_W-1:0]    FTW,
    output logic [DATA_W-1:0]   PHASE,
    output logic [DATA_W-1:0]   AMPL,
    output logic [WAVE_W-1:0]   WAVE_SEL,
    output logic                UPDATE
);

    localparam int unsigned SETTLE_W = 2;

    logic ne1_s, ne1_rise, ne1_fall;
    logic nadv_s, nadv_rise, nadv_fall;
    logic nwe_s, nwe_rise, nwe_fall;

    fsmc_sync #(.STAGES(SYNC_STAGES)) u_sync_ne1 (
        .clk(CLK), .rst(RST), .d(bus.NE1), .level(ne1_s), .rise_c(ne1_rise), .fall_c(ne1_fall)
    );
    fsmc_sync #(.STAGES(SYNC_STAGES)) u_sync_nadv (
        .clk(CLK), .rst(RST), .d(bus.NADV), .level(nadv_s), .rise_c(nadv_rise), .fall_c(nadv_fall)
    );
    fsmc_sync #(.STAGES(SYNC_STAGES)) u_sync_nwe (
        .clk(CLK), .rst(RST), .d(bus.NWE), .level(nwe_s), .rise_c(nwe_rise), .fall_c(nwe_fall)
    );

    fsm_state_e            state_q, state_d;
    logic                  armed_q, armed_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [REGION_W-1:0]   region_q, region_d;
    logic [OFFSET_W-1:0]   offset_q, offset_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    dds_shadow_t           shadow_q, shadow_d;
    dds_active_t           active_q, active_d;
    logic [DATA_W-1:0]     status_q, status_d;
    logic                  update_q, update_d;
    logic                  settled_c;
    logic                  hit_c;

`ifdef FSMC_DDS_READBACK_EN
    logic noe_s, noe_rise, noe_fall;

    fsmc_sync #(.STAGES(SYNC_STAGES)) u_sync_noe (
        .clk(CLK), .rst(RST), .d(bus.NOE), .level(noe_s), .rise_c(noe_rise), .fall_c(noe_fall)
    );
`endif

    assign settled_c = (settle_q == SETTLE_W'(SYNC_STAGES));
    assign hit_c     = (region_q == BASE_REGION);

    // Bus FSM, address/data capture, shadow writes and commit to the active set.
    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        settle_d = settle_q;
        region_d = region_q;
        offset_d = offset_q;
        wdata_d  = wdata_q;
        shadow_d = shadow_q;
        active_d = active_q;
        status_d = status_q;
        update_d = 1'b0;

        // After reset, wait for the synchronizers to reflect the pins, then
        // only accept a new transaction once the bus has been seen deselected.
        if (!settled_c) begin
            settle_d = settle_q + SETTLE_W'(1);
        end
        armed_d = armed_q | ne1_rise | (settled_c & ne1_s);

        case (state_q)
            ST_IDLE: begin
                if (armed_q && nadv_fall && !ne1_s) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (nadv_rise) begin
                    state_d  = ST_HOLD;
                    region_d = {bus.A18, bus.A17, bus.A16, bus.AD_IN[DATA_W-1]};
                    offset_d = bus.AD_IN[OFFSET_W-1:0];
                end
            end
            ST_HOLD: begin
                if (nwe_rise) begin
                    state_d = ST_WRITE;
                    wdata_d = bus.AD_IN;
                end
`ifdef FSMC_DDS_READBACK_EN
                else if (noe_fall) begin
                    state_d = ST_READ;
                end
`endif
            end
            ST_WRITE: begin
                state_d = ST_WAIT;
                if (hit_c) begin
                    case (offset_q)
                        OFF_FTW_LO: shadow_d.ftw[DATA_W-1:0]     = wdata_q;
                        OFF_FTW_HI: shadow_d.ftw[FTW_W-1:DATA_W] = wdata_q;
                        OFF_PHASE:  shadow_d.phase               = wdata_q;
                        OFF_AMPL:   shadow_d.ampl                = wdata_q;
                        OFF_CTRL: begin
                            shadow_d.ctrl = wdata_q[CTRL_W-1:0];
                            if (wdata_q[CTRL_COMMIT_BIT]) begin
                                active_d.ftw   = shadow_q.ftw;
                                active_d.phase = shadow_q.phase;
                                active_d.ampl  = shadow_q.ampl;
                                active_d.wave  = wdata_q[WAVE_W-1:0];
                                update_d       = 1'b1;
                                status_d       = status_q + 16'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
`ifdef FSMC_DDS_READBACK_EN
            ST_READ: begin
                if (noe_rise) begin
                    state_d = ST_WAIT;
                end
            end
`endif
            ST_WAIT: ;
            default: state_d = ST_IDLE;
        endcase

        if (ne1_rise) begin
            state_d = ST_IDLE;
        end
    end

    // Control, shadow, active and status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            armed_q  <= 1'b0;
            settle_q <= '0;
            region_q <= '0;
            offset_q <= '0;
            wdata_q  <= '0;
            shadow_q <= '0;
            active_q <= '0;
            status_q <= '0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            settle_q <= settle_d;
            region_q <= region_d;
            offset_q <= offset_d;
            wdata_q  <= wdata_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            status_q <= status_d;
            update_q <= update_d;
        end
    end

    assign FTW      = active_q.ftw;
    assign PHASE    = active_q.phase;
    assign AMPL     = active_q.ampl;
    assign WAVE_SEL = active_q.wave;
    assign UPDATE   = update_q;

`ifdef FSMC_DDS_READBACK_EN
    logic [DATA_W-1:0] rdata_c;
    logic [DATA_W-1:0] ad_out_q, ad_out_d;
    logic              ad_oe_q, ad_oe_d;
    logic              unused_c;

    // Readback mux; CTRL commit bit always reads as zero.
    always_comb begin
        rdata_c = '0;
        case (offset_q)
            OFF_FTW_LO: rdata_c = shadow_q.ftw[DATA_W-1:0];
            OFF_FTW_HI: rdata_c = shadow_q.ftw[FTW_W-1:DATA_W];
            OFF_PHASE:  rdata_c = shadow_q.phase;
            OFF_AMPL:   rdata_c = shadow_q.ampl;
            OFF_CTRL:   rdata_c = {1'b0, shadow_q.ctrl};
            OFF_STATUS: rdata_c = status_q;
            OFF_ID:     rdata_c = ID_VALUE;
            default:    rdata_c = '0;
        endcase
    end

    // Drive enable follows READ on a hit; data lands one cycle after entering READ.
    always_comb begin
        ad_oe_d  = (state_d == ST_READ) && hit_c;
        ad_out_d = ((state_q == ST_READ) && (state_d == ST_READ) && hit_c) ? rdata_c : '0;
    end

    // Registered bus outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ad_oe_q  <= 1'b0;
            ad_out_q <= '0;
        end else begin
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
        end
    end

    assign bus.AD_OE  = ad_oe_q;
    assign bus.AD_OUT = ad_out_q;
    assign unused_c   = ^{ne1_fall, nadv_s, nwe_s, nwe_fall, noe_s};
`else
    logic unused_c;

    assign bus.AD_OE  = 1'b0;
    assign bus.AD_OUT = '0;
    assign unused_c   = ^{ne1_fall, nadv_s, nwe_s, nwe_fall, bus.NOE, status_q,
                          shadow_q.ctrl[CTRL_W-1:WAVE_W]};
`endif

endmodule

// File: doc/fsmc_dds_regs.md
FSMC_DDS_REGS -- requirements
Module: fsmc_dds_regs

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on FSMC control inputs (legal 2..3).
REQ-002 SHALL have parameter BASE_REGION, default 4'b1010, meaning the value of ADDR[18:15] that selects this block.
REQ-003 SHALL have ports with one clock, CLK (input, 1 bit), and reset RST (input, 1 bit); RST is synchronous and active-high.
REQ-004 SHALL have NE1  input  1  FSMC chip select, active-low.
REQ-005 SHALL have NADV  input  1  FSMC address-valid, active-low.
REQ-006 SHALL have NWE  input  1  FSMC write strobe, active-low.
REQ-007 SHALL have NOE  input  1  FSMC read strobe, active-low.
REQ-008 SHALL have AD_IN  input  16  multiplexed address/data bus, input side.
REQ-009 SHALL have A16, A17, A18  input  1 each  upper address bits.
REQ-010 SHALL have AD_OUT  output  16  read data; AD_OE  output  1  bus drive enable, active-high.
REQ-011 SHALL have FTW  output  32  active DDS frequency tuning word.
REQ-012 SHALL have PHASE  output  16  active phase offset; AMPL  output  16  active amplitude; WAVE_SEL  output  2  active waveform.
REQ-013 SHALL have UPDATE  output  1  one-cycle pulse when the active registers change.

Function
REQ-014 SHALL pass NE1, NADV, NWE and NOE through SYNC_STAGES flops and derive rising and falling edges of the synchronized signals.
REQ-015 SHALL run FSM IDLE -> ADDR on sync NADV fall with sync NE1 low; ADDR -> HOLD on sync NADV rise, latching ADDR = {A18,A17,A16,AD_IN}.
REQ-016 SHALL move HOLD -> WRITE on sync NWE rise, capture AD_IN that cycle, then go to WAIT.
REQ-017 SHALL move HOLD -> READ on sync NOE fall; READ -> WAIT on sync NOE rise.
REQ-018 SHALL move any state -> IDLE on sync NE1 rise; WAIT holds until then.
REQ-019 SHALL act on a write only if ADDR[18:15] equals BASE_REGION; all other writes are ignored.
REQ-020 SHALL decode the word offset from ADDR[3:0]: 0 FTW_LO, 1 FTW_HI, 2 PHASE, 3 AMPL, 4 CTRL, 5 STATUS (read-only), 7 ID (read-only, 16'hDD50); other offsets read 16'h0000 and ignore writes.
REQ-021 SHALL let writes update shadow registers only; CTRL[1:0] is the shadow WAVE_SEL.
REQ-022 SHALL, on a CTRL write with bit15 = 1, copy all shadows to the active outputs on the next CLK, pulse UPDATE for exactly one cycle, and increment an 16-bit wrapping commit counter (STATUS).
REQ-023 SHALL, when a CTRL commit write also carries new CTRL[1:0], apply the new WAVE_SEL value in the same commit.
REQ-024 SHALL read back shadow registers for offsets 0-4; CTRL bit15 reads 0.
REQ-025 SHALL drive AD_OE high only in READ with a region hit; AD_OUT is registered, valid one cycle after entering READ, and 0 otherwise.
REQ-026 SHALL require FSMC timing ADDHLD and DATAST each >= SYNC_STAGES+2 CLK periods; behaviour is undefined for shorter timing.

Reset
REQ-027 SHALL, while RST is high, set FSM to IDLE, shadows and actives to 0, STATUS to 0, UPDATE, AD_OE and AD_OUT to 0, and synchronizer flops to 1.
REQ-028 SHALL, on reset released mid-transaction, ignore all strobes until a sync NE1 rise is seen.

Configuration
REQ-029 SHALL, with macro FSMC_DDS_READBACK_EN defined, implement the READ state and readback per REQ-017, REQ-024 and REQ-025.
REQ-030 SHALL, without FSMC_DDS_READBACK_EN, omit the READ state, tie AD_OE and AD_OUT to 0, and treat NOE as ignored; the write path is unchanged.

Structure
REQ-031 SHALL place register offsets, the ID constant, the FSM state encoding and the BASE_REGION default in shared package fsmc_dds_pkg.
REQ-032 SHALL implement the synchronizer and edge detect as sub-module fsmc_sync, instantiated once per control input.

Verification
REQ-033 SHALL cover: write 0x1234 to offset 0, 0xABCD to offset 1, then CTRL 0x8000 -> FTW = 0xABCD1234, UPDATE high for 1 cycle, STATUS = 1.
REQ-034 SHALL cover: write PHASE 0x0100 without commit -> PHASE output stays 0, readback of offset 2 = 0x0100.
REQ-035 SHALL cover: write with ADDR[18:15] = 4'b0101 -> no shadow change, AD_OE stays 0 on a read to that address.
REQ-036 SHALL cover: read offset 7 -> AD_OUT = 0xDD50 with AD_OE high only during NOE low.
REQ-037 SHALL cover: RST asserted between NADV rise and NWE rise -> no write applied and all outputs 0; the next full transaction succeeds.
REQ-038 SHALL cover: 65536 commits -> STATUS wraps to 0x0000.
